// File: rtl/ivector_unpack.sv
// ivector_unpack: dequeues one {.., c, b, a} vector per upstream handshake and
// re-emits its elements a, b, c, ... one word at a time through a guarded enq.
// Back-to-back vectors stream at one word per cycle with no bubble.
// Optional feature macro: IVECTOR_UNPACK_LAST_EN adds out_enq_last, which is
// high while the final element of a vector is being offered.
module ivector_unpack #(
  parameter int WIDTH = 32,
  parameter int ELEMS = 3
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [WIDTH*ELEMS-1:0] in_first,
  input  logic                   in_first__RDY,
  input  logic                   in_deq__RDY,
  output logic                   in_deq__ENA,
  output logic [WIDTH-1:0]       out_enq_v,
  input  logic                   out_enq__RDY,
  output logic                   out_enq__ENA,
  output logic                   busy
`ifdef IVECTOR_UNPACK_LAST_EN
  ,
  output logic                   out_enq_last
`endif
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} st_t;

  localparam logic [1:0] LAST_IDX = 2'(ELEMS - 1);

  st_t                   st_q, st_d;
  logic [WIDTH*ELEMS-1:0] hold_q, hold_d;
  logic [1:0]            idx_q, idx_d;

  logic       sending;
  logic       last_xfer;
  logic       load;
  logic       enq_ena;
  logic [WIDTH-1:0] cur_word;

  // Handshake decode; deq is suppressed while reset is held so nothing is consumed
  always_comb begin
    sending   = (st_q == SEND);
    enq_ena   = sending & out_enq__RDY;
    last_xfer = enq_ena & (idx_q == LAST_IDX);
    load      = ~RST & in_first__RDY & in_deq__RDY & (~sending | last_xfer);
  end

  // Select the element addressed by idx from the captured vector
  always_comb begin
    cur_word = '0;
    for (int k = 0; k < ELEMS; k++) begin
      if (idx_q == 2'(k)) cur_word = hold_q[k*WIDTH +: WIDTH];
    end
  end

  // Output drive; the word bus reads zero whenever nothing is being offered
  always_comb begin
    in_deq__ENA  = load;
    out_enq__ENA = enq_ena;
    out_enq_v    = sending ? cur_word : '0;
    busy         = sending;
  end

`ifdef IVECTOR_UNPACK_LAST_EN
  // End-of-vector marker accompanies the final element
  always_comb begin
    out_enq_last = sending & (idx_q == LAST_IDX);
  end
`endif

  // Next-state: a load wins over the final transfer so back-to-back vectors chain
  always_comb begin
    st_d   = st_q;
    hold_d = hold_q;
    idx_d  = idx_q;
    if (load) begin
      hold_d = in_first;
      idx_d  = '0;
      st_d   = SEND;
    end else if (enq_ena) begin
      if (idx_q == LAST_IDX) begin
        st_d  = IDLE;
        idx_d = '0;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end
  end

  // State registers; reset drops any partially sent vector
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st_q   <= IDLE;
      hold_q <= '0;
      idx_q  <= '0;
    end else begin
      st_q   <= st_d;
      hold_q <= hold_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: tb/tb_ivector_unpack.sv
// Directed bench for ivector_unpack: single vector, back-to-back vectors,
// output backpressure, upstream not ready, asynchronous reset mid-vector,
// and (when IVECTOR_UNPACK_LAST_EN is defined) the end-of-vector marker.
module tb_ivector_unpack;

  localparam int WIDTH = 32;
  localparam int ELEMS = 3;

  logic                   clk;
  logic                   rst;
  logic [WIDTH*ELEMS-1:0] first;
  logic                   first_rdy;
  logic                   deq_rdy;
  logic                   deq_ena;
  logic [WIDTH-1:0]       enq_v;
  logic                   enq_rdy;
  logic                   enq_ena;
  logic                   busy;
`ifdef IVECTOR_UNPACK_LAST_EN
  logic                   enq_last;
`endif

  int total = 0;
  int bad   = 0;

  ivector_unpack #(.WIDTH(WIDTH), .ELEMS(ELEMS)) dut (
    .CLK           (clk),
    .RST           (rst),
    .in_first      (first),
    .in_first__RDY (first_rdy),
    .in_deq__RDY   (deq_rdy),
    .in_deq__ENA   (deq_ena),
    .out_enq_v     (enq_v),
    .out_enq__RDY  (enq_rdy),
    .out_enq__ENA  (enq_ena),
    .busy          (busy)
`ifdef IVECTOR_UNPACK_LAST_EN
    ,
    .out_enq_last  (enq_last)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; return at the falling edge so inputs change away from posedge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Check all handshake outputs for the current cycle
  task automatic expect_cycle(input string tag, input logic d, input logic e,
                              input logic [31:0] v, input logic b);
    #1;
    check({tag, ".deq"},  32'(deq_ena), 32'(d));
    check({tag, ".ena"},  32'(enq_ena), 32'(e));
    check({tag, ".v"},    enq_v,        v);
    check({tag, ".busy"}, 32'(busy),    32'(b));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst.deq",  32'(deq_ena), 32'd0);
    check("rst.ena",  32'(enq_ena), 32'd0);
    check("rst.v",    enq_v,        32'd0);
    check("rst.busy", 32'(busy),    32'd0);
`ifdef IVECTOR_UNPACK_LAST_EN
    check("rst.last", 32'(enq_last), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    first     = '0;
    first_rdy = 1'b1;
    deq_rdy   = 1'b1;
    enq_rdy   = 1'b1;
    do_reset();

    // Scenario 1: one vector, words AA, BB, CC in cycles 1..3
    first     = {32'h000000CC, 32'h000000BB, 32'h000000AA};
    first_rdy = 1'b1;
    deq_rdy   = 1'b1;
    enq_rdy   = 1'b1;
    expect_cycle("s1.c0", 1'b1, 1'b0, 32'h0, 1'b0);
    step();
    first_rdy = 1'b0;
    expect_cycle("s1.c1", 1'b0, 1'b1, 32'hAA, 1'b1);
`ifdef IVECTOR_UNPACK_LAST_EN
    check("s1.c1.last", 32'(enq_last), 32'd0);
`endif
    step();
    expect_cycle("s1.c2", 1'b0, 1'b1, 32'hBB, 1'b1);
`ifdef IVECTOR_UNPACK_LAST_EN
    check("s1.c2.last", 32'(enq_last), 32'd0);
`endif
    step();
    expect_cycle("s1.c3", 1'b0, 1'b1, 32'hCC, 1'b1);
`ifdef IVECTOR_UNPACK_LAST_EN
    check("s1.c3.last", 32'(enq_last), 32'd1);
`endif
    step();
    expect_cycle("s1.c4", 1'b0, 1'b0, 32'h0, 1'b0);
`ifdef IVECTOR_UNPACK_LAST_EN
    check("s1.c4.last", 32'(enq_last), 32'd0);
`endif

    // Scenario 2: back-to-back vectors, words 1..6 with no bubble
    first     = {32'd3, 32'd2, 32'd1};
    first_rdy = 1'b1;
    expect_cycle("s2.c0", 1'b1, 1'b0, 32'h0, 1'b0);
    step();
    first = {32'd6, 32'd5, 32'd4};
    expect_cycle("s2.c1", 1'b0, 1'b1, 32'd1, 1'b1);
    step();
    expect_cycle("s2.c2", 1'b0, 1'b1, 32'd2, 1'b1);
    step();
    expect_cycle("s2.c3", 1'b1, 1'b1, 32'd3, 1'b1);
    step();
    first_rdy = 1'b0;
    first     = '0;
    expect_cycle("s2.c4", 1'b0, 1'b1, 32'd4, 1'b1);
    step();
    expect_cycle("s2.c5", 1'b0, 1'b1, 32'd5, 1'b1);
    step();
    expect_cycle("s2.c6", 1'b0, 1'b1, 32'd6, 1'b1);
    step();
    expect_cycle("s2.c7", 1'b0, 1'b0, 32'h0, 1'b0);

    // Scenario 3: backpressure after AA; a pending upstream vector must wait
    first     = {32'h000000CC, 32'h000000BB, 32'h000000AA};
    first_rdy = 1'b1;
    expect_cycle("s3.c0", 1'b1, 1'b0, 32'h0, 1'b0);
    step();
    first = {32'h00000077, 32'h00000066, 32'h00000055};
    expect_cycle("s3.c1", 1'b0, 1'b1, 32'hAA, 1'b1);
    step();
    enq_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_cycle($sformatf("s3.stall%0d", i), 1'b0, 1'b0, 32'hBB, 1'b1);
      step();
    end
    enq_rdy = 1'b1;
    expect_cycle("s3.bb", 1'b0, 1'b1, 32'hBB, 1'b1);
    step();
    expect_cycle("s3.cc", 1'b1, 1'b1, 32'hCC, 1'b1);
    step();
    first_rdy = 1'b0;
    first     = '0;
    expect_cycle("s3.n0", 1'b0, 1'b1, 32'h55, 1'b1);
    step();
    expect_cycle("s3.n1", 1'b0, 1'b1, 32'h66, 1'b1);
    step();
    expect_cycle("s3.n2", 1'b0, 1'b1, 32'h77, 1'b1);
    step();
    expect_cycle("s3.idle", 1'b0, 1'b0, 32'h0, 1'b0);

    // Scenario 4: head valid but upstream refuses dequeue
    first     = {32'h3, 32'h2, 32'h1};
    first_rdy = 1'b1;
    deq_rdy   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_cycle($sformatf("s4.c%0d", i), 1'b0, 1'b0, 32'h0, 1'b0);
      step();
    end

    // Scenario 5: asynchronous reset after AA drops the rest of the vector
    first   = {32'h000000CC, 32'h000000BB, 32'h000000AA};
    deq_rdy = 1'b1;
    expect_cycle("s5.c0", 1'b1, 1'b0, 32'h0, 1'b0);
    step();
    first_rdy = 1'b0;
    expect_cycle("s5.c1", 1'b0, 1'b1, 32'hAA, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("s5.async.deq",  32'(deq_ena), 32'd0);
    check("s5.async.ena",  32'(enq_ena), 32'd0);
    check("s5.async.v",    enq_v,        32'd0);
    check("s5.async.busy", 32'(busy),    32'd0);
    step();
    rst = 1'b0;
    expect_cycle("s5.after", 1'b0, 1'b0, 32'h0, 1'b0);
    first     = {32'h00000033, 32'h00000022, 32'h00000011};
    first_rdy = 1'b1;
    expect_cycle("s5.r0", 1'b1, 1'b0, 32'h0, 1'b0);
    step();
    first_rdy = 1'b0;
    expect_cycle("s5.r1", 1'b0, 1'b1, 32'h11, 1'b1);
    step();
    expect_cycle("s5.r2", 1'b0, 1'b1, 32'h22, 1'b1);
    step();
    expect_cycle("s5.r3", 1'b0, 1'b1, 32'h33, 1'b1);
    step();
    expect_cycle("s5.r4", 1'b0, 1'b0, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
